// File: rtl/multi_stepper_ctrl_if.sv
// Command/status bundle between the motion sequencer and the multi-axis stepper controller.
interface multi_stepper_ctrl_if #(
    parameter int NUM_AXES         = 2,
    parameter int PULSE_NUM_BITS   = 8,
    parameter int PULSE_WIDTH_BITS = 8
);
    logic                                 clk_en;
    logic                                 trigger;
    logic                                 abort;
    logic [NUM_AXES*PULSE_NUM_BITS-1:0]   pulse_num;
    logic [NUM_AXES*PULSE_WIDTH_BITS-1:0] pulse_width;
    logic                                 busy;
    logic                                 done;
    logic [NUM_AXES-1:0]                  out;
    logic [NUM_AXES-1:0]                  dir;

    modport master (
        output clk_en, trigger, abort, pulse_num, pulse_width,
        input  busy, done, out, dir
    );

    modport slave (
        input  clk_en, trigger, abort, pulse_num, pulse_width,
        output busy, done, out, dir
    );
endinterface

// File: rtl/multi_stepper_ctrl.sv
// N-axis step/dir generator: one trigger launches all axes, done pulses when every axis finishes.
// Optional start-up ramp on each axis is enabled by defining STEPPER_RAMP_EN.
//
// state | meaning
// IDLE  | waiting for trigger; operands latched on acceptance
// RUN   | axes pulsing; leaves when every axis count is zero
// DONE  | single-cycle done pulse, then back to IDLE
module multi_stepper_ctrl #(
    parameter int NUM_AXES         = 2,
    parameter int PULSE_NUM_BITS   = 8,
    parameter int PULSE_WIDTH_BITS = 8,
    parameter int RAMP_STEPS       = 2
) (
    input logic                 clk,
    input logic                 reset,
    multi_stepper_ctrl_if.slave bus
);
    localparam int PN = PULSE_NUM_BITS;
    localparam int PW = PULSE_WIDTH_BITS;
`ifdef STEPPER_RAMP_EN
    localparam int WW = PW + RAMP_STEPS;
    localparam int KW = $clog2(RAMP_STEPS + 2);

    function automatic logic [WW-1:0] ramp_w(input logic [PW-1:0] w, input logic [KW-1:0] kk);
        if (kk < KW'(RAMP_STEPS))
            return WW'(w) << (KW'(RAMP_STEPS) - kk);
        return WW'(w);
    endfunction
`else
    localparam int WW = PW + 0 * RAMP_STEPS;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic                accept;
    logic [NUM_AXES-1:0] ax_done;
    logic                all_done;

    assign accept   = (state_q == IDLE) && bus.trigger && !bus.abort;
    assign all_done = &ax_done;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.trigger) state_d = RUN;
            RUN:     if (all_done)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort)
            state_d = IDLE;
    end

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        logic [PN-1:0] pn_i, mag_i, cnt;
        logic [PW-1:0] pw_i, width;
        logic [WW-1:0] ph, cur_w, nxt_w;
        logic          out_r, dir_r, started;

        assign pn_i  = bus.pulse_num[i*PN +: PN];
        assign pw_i  = bus.pulse_width[i*PW +: PW];
        // Unsigned magnitude: the most negative input maps to 2**(PN-1) pulses.
        assign mag_i = pn_i[PN-1] ? ((~pn_i) + PN'(1)) : pn_i;

`ifdef STEPPER_RAMP_EN
        logic [KW-1:0] k, k_nxt;
        assign k_nxt = (k < KW'(RAMP_STEPS)) ? k + KW'(1) : k;
        assign cur_w = ramp_w(width, k);
        assign nxt_w = ramp_w(width, k_nxt);
`else
        assign cur_w = WW'(width);
        assign nxt_w = cur_w;
`endif

        assign ax_done[i]  = (cnt == '0);
        assign bus.out[i]  = out_r;
        assign bus.dir[i]  = dir_r;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt     <= '0;
                width   <= '0;
                ph      <= '0;
                out_r   <= 1'b0;
                dir_r   <= 1'b0;
                started <= 1'b0;
`ifdef STEPPER_RAMP_EN
                k       <= '0;
`endif
            end else if (bus.abort) begin
                cnt     <= '0;
                ph      <= '0;
                out_r   <= 1'b0;
                started <= 1'b0;
            end else if (accept) begin
                dir_r   <= pn_i[PN-1];
                width   <= pw_i;
                cnt     <= (pw_i == '0) ? '0 : mag_i;
                ph      <= '0;
                out_r   <= 1'b0;
                started <= 1'b0;
`ifdef STEPPER_RAMP_EN
                k       <= '0;
`endif
            end else if (state_q == RUN && bus.clk_en && cnt != '0) begin
                if (ph != '0) begin
                    ph <= ph - WW'(1);
                end else if (out_r) begin
                    out_r <= 1'b0;
                    ph    <= cur_w - WW'(1);
                end else if (!started) begin
                    started <= 1'b1;
                    out_r   <= 1'b1;
                    ph      <= cur_w - WW'(1);
                end else begin
                    // End of a low phase: one pulse complete.
                    cnt <= cnt - PN'(1);
`ifdef STEPPER_RAMP_EN
                    k   <= k_nxt;
`endif
                    if (cnt != PN'(1)) begin
                        out_r <= 1'b1;
                        ph    <= nxt_w - WW'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_stepper_ctrl.sv
// Scoreboard bench for multi_stepper_ctrl: stimulus pushes expected move results, a monitor checks them.
module tb_multi_stepper_ctrl;
    localparam int RAMP = 2;

    logic clk;
    logic reset;

    multi_stepper_ctrl_if #(.NUM_AXES(2), .PULSE_NUM_BITS(8), .PULSE_WIDTH_BITS(8)) bus ();

    multi_stepper_ctrl #(
        .NUM_AXES(2), .PULSE_NUM_BITS(8), .PULSE_WIDTH_BITS(8), .RAMP_STEPS(RAMP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int         p0;
        int         p1;
        logic [1:0] dir;
        int         w0;
        int         w1;
        bit         exp_done;
        int         ticks;
        int         run_clks;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.clk_en = 1'b0;
        forever begin
            @(negedge clk);
            bus.clk_en = ~bus.clk_en;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int hw(input int w, input int k);
`ifdef STEPPER_RAMP_EN
        return (k < RAMP) ? (w << (RAMP - k)) : w;
`else
        return (k >= 0) ? w : 0;
`endif
    endfunction

    function automatic int axis_ticks(input int n, input int w);
        int t = 0;
        if (w == 0) return 0;
        for (int k = 0; k < n; k++) t += 2 * hw(w, k);
        return t;
    endfunction

    // Ticks from acceptance through the finishing tick, plus the edge into DONE.
    function automatic int move_ticks(input int n0, input int w0, input int n1, input int w1);
        int a, b;
        a = axis_ticks(n0, w0);
        b = axis_ticks(n1, w1);
        return ((a > b) ? a : b) + 1;
    endfunction

    task automatic push(input int p0, input int p1, input logic [1:0] d, input int w0,
                        input int w1, input bit ed, input int tk, input int rc);
        exp_t e;
        e.p0 = p0; e.p1 = p1; e.dir = d; e.w0 = w0; e.w1 = w1;
        e.exp_done = ed; e.ticks = tk; e.run_clks = rc;
        sb.push_back(e);
    endtask

    task automatic start_move(input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] w0, input logic [7:0] w1, input int hold);
        @(negedge clk);
        bus.pulse_num   = {p1, p0};
        bus.pulse_width = {w1, w0};
        bus.trigger     = 1'b1;
        repeat (hold) @(negedge clk);
        bus.trigger = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || bus.done) && n < budget);
        if (bus.busy || bus.done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout busy=%0b done=%0b after %0d clks", name, bus.busy, bus.done, n);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic       busy_p, done_p, tk;
        logic [1:0] out_p;
        int         rises[2], len[2], wexp[2];
        int         tick_cnt, clk_cnt;
        bit         active;
        exp_t       r;
        busy_p = 0; done_p = 0; out_p = 0; active = 0;
        tick_cnt = 0; clk_cnt = 0;
        for (int i = 0; i < 2; i++) begin rises[i] = 0; len[i] = 0; wexp[i] = 0; end
        forever begin
            @(posedge clk);
            tk = bus.clk_en;
            #1;
            if (reset) begin
                busy_p = 0; done_p = 0; out_p = 0;
                continue;
            end
            if (bus.busy && !busy_p) begin
                if (sb.size() == 0) begin
                    check("unexpected_start", 1, 0);
                    active = 0;
                end else begin
                    active  = 1;
                    wexp[0] = sb[0].w0;
                    wexp[1] = sb[0].w1;
                end
                tick_cnt = 0; clk_cnt = 0;
                for (int i = 0; i < 2; i++) begin rises[i] = 0; len[i] = 0; end
            end else if (busy_p) begin
                clk_cnt++;
                if (tk) tick_cnt++;
                for (int i = 0; i < 2; i++) begin
                    if (tk) len[i]++;
                    if (bus.out[i] != out_p[i]) begin
                        if (bus.out[i]) begin
                            if (bus.busy && active && rises[i] > 0)
                                check($sformatf("low_len_ax%0d_p%0d", i, rises[i] - 1), len[i], hw(wexp[i], rises[i] - 1));
                            rises[i]++;
                        end else if (bus.busy && active) begin
                            check($sformatf("high_len_ax%0d_p%0d", i, rises[i] - 1), len[i], hw(wexp[i], rises[i] - 1));
                        end
                        len[i] = 0;
                    end
                end
                if (!bus.busy) begin
                    if (sb.size() == 0) begin
                        check("unexpected_end", 1, 0);
                    end else begin
                        r = sb.pop_front();
                        check("done_at_end", int'(bus.done), int'(r.exp_done));
                        check("pulses_ax0", rises[0], r.p0);
                        check("pulses_ax1", rises[1], r.p1);
                        check("dir", int'(bus.dir), int'(r.dir));
                        check("out_after_end", int'(bus.out), 0);
                        if (r.exp_done && r.ticks >= 0) check("move_ticks", tick_cnt, r.ticks);
                        if (r.run_clks >= 0) check("run_clks", clk_cnt, r.run_clks);
                    end
                    active = 0;
                end
            end
            if (done_p) check("done_one_clk", int'(bus.done), 0);
            if (bus.done && !busy_p) check("done_without_run", 1, 0);
            out_p  = bus.out;
            busy_p = bus.busy;
            done_p = bus.done;
        end
    end

    initial begin
        int n;
        reset           = 1'b1;
        bus.trigger     = 1'b0;
        bus.abort       = 1'b0;
        bus.pulse_num   = '0;
        bus.pulse_width = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_out", int'(bus.out), 0);
        check("reset_dir", int'(bus.dir), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Zero move: one RUN clock then DONE, no pulses.
        push(0, 0, 2'b00, 5, 5, 1, -1, 1);
        start_move(8'd0, 8'd0, 8'd5, 8'd5, 2);
        wait_idle("zero", 20);

        // Signed dual move: -4/w2 and 2/w3 -> 17 ticks including the edge into DONE.
        push(4, 2, 2'b01, 2, 3, 1, move_ticks(4, 2, 2, 3), -1);
        start_move(8'hFC, 8'd2, 8'd2, 8'd3, 1);
        wait_idle("dual", 200);

        // Most negative count -> 128 pulses, 257 ticks.
        push(128, 0, 2'b01, 1, 0, 1, move_ticks(128, 1, 0, 0), -1);
        start_move(8'h80, 8'd0, 8'd1, 8'd0, 1);
        wait_idle("minneg", 2000);

        // Abort after tick 7: axis0 has risen at t1,t5; axis1 (w3) at t1,t7 and is high.
        push(2, 2, 2'b10, 2, 3, 0, -1, -1);
        start_move(8'd10, 8'hFB, 8'd2, 8'd3, 1);
        n = 0;
        for (int c = 0; c < 100 && n < 7; c++) begin
            @(posedge clk);
            if (bus.clk_en) n++;
        end
        check("abort_tick_reached", n, 7);
        @(negedge clk);
        check("abort_pre_out1", int'(bus.out[1]), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_out", int'(bus.out), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_dir_kept", int'(bus.dir), 2'b10);
        repeat (4) @(negedge clk);
        check("abort_no_done", int'(bus.done), 0);

        push(3, 1, 2'b01, 1, 1, 1, move_ticks(3, 1, 1, 1), -1);
        start_move(8'hFD, 8'd1, 8'd1, 8'd1, 1);
        wait_idle("after_abort", 100);

        // Trigger pulse during RUN is ignored: counts stay 3 and 2.
        push(3, 2, 2'b00, 1, 2, 1, move_ticks(3, 1, 2, 2), -1);
        start_move(8'd3, 8'd2, 8'd1, 8'd2, 1);
        repeat (4) @(negedge clk);
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        wait_idle("run_trigger", 100);

        // Trigger held through DONE: a second identical move starts right after.
        push(1, 2, 2'b10, 1, 1, 1, move_ticks(1, 1, 2, 1), -1);
        push(1, 2, 2'b10, 1, 1, 1, move_ticks(1, 1, 2, 1), -1);
        @(negedge clk);
        bus.pulse_num   = {8'hFE, 8'd1};
        bus.pulse_width = {8'd1, 8'd1};
        bus.trigger     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        check("held_done_seen", int'(bus.done), 1);
        @(negedge clk);
        check("held_idle_busy", int'(bus.busy), 0);
        @(negedge clk);
        check("held_restart_busy", int'(bus.busy), 1);
        bus.trigger = 1'b0;
        wait_idle("held_retrigger", 100);

`ifdef STEPPER_RAMP_EN
        // Ramp: 3/w2 -> half-periods 8, 4, 2; 29 ticks.
        push(3, 0, 2'b00, 2, 0, 1, move_ticks(3, 2, 0, 0), -1);
        start_move(8'd3, 8'd0, 8'd2, 8'd0, 1);
        wait_idle("ramp", 200);
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_stepper_ctrl.md
Name: multi_stepper_ctrl

Overview:
- N-axis successor to the single-channel stepper controller. One trigger starts all axes together; each axis emits a signed number of step pulses with its own pulse width.
- Reports busy and a single-cycle done when every axis has finished, so the motion sequencer can issue coordinated multi-axis moves.
- Sits between the motion/command processor and the stepper driver pins. Timing is paced by the shared clk_en tick from the frequency divider.

Parameters:
- NUM_AXES, 2, number of independent step/dir channels (>=1).
- PULSE_NUM_BITS, 8, width of each signed pulse count (two's complement).
- PULSE_WIDTH_BITS, 8, width of each unsigned half-period in clk_en ticks.
- RAMP_STEPS, 2, number of start-up ramp pulses. Used only with STEPPER_RAMP_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  timing tick; all pulse timing counts clk cycles where clk_en=1
- trigger  in  1  start request; level, accepted only in IDLE
- abort  in  1  stop all axes immediately; no done pulse
- pulse_num  in  NUM_AXES*PULSE_NUM_BITS  signed count per axis; axis i occupies slice [i*PULSE_NUM_BITS +: PULSE_NUM_BITS]; sign selects dir
- pulse_width  in  NUM_AXES*PULSE_WIDTH_BITS  per-axis high time = low time, in clk_en ticks
- busy  out  1  high while in RUN
- done  out  1  one-clk pulse when all axes have completed
- out  out  NUM_AXES  step pulse per axis
- dir  out  NUM_AXES  direction per axis; 1 = negative pulse_num

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, out=0, dir=0; all counters cleared.
- FSM states:
  - IDLE: on a clk edge with trigger=1 and abort=0, latch every axis's operands and go to RUN. This happens independently of clk_en.
  - RUN: when all axes are finished, go to DONE.
  - DONE: lasts one clk cycle with done=1, then returns to IDLE.
- trigger is ignored outside IDLE. A trigger held high through DONE starts a new move in the following IDLE cycle.
- Latching per axis:
  - dir[i] = sign bit; dir holds until the next accepted trigger.
  - Magnitude = |pulse_num|, held as a PULSE_NUM_BITS-bit unsigned value, so the most negative value (-128 at 8 bits) gives 128 pulses.
  - width = pulse_width.
- An axis with magnitude=0 or width=0 is finished immediately and never pulses. If every axis is such, the block goes RUN for one cycle, then DONE.
- Pulse generation per active axis:
  - out rises on the first clk_en tick after acceptance.
  - out stays high for width ticks, then low for width ticks. That is one pulse.
  - The remaining count decrements at the end of the low phase. The next pulse starts on the following tick.
  - The axis is finished when the count reaches 0. out stays 0 afterwards.
- Axes run concurrently and independently. busy deasserts on the transition to DONE.
- abort=1 in any state: next clk edge forces IDLE, out=0, busy=0, no done pulse. dir keeps its value. abort has priority over a simultaneous trigger and over completion.
- clk_en=0 freezes all phase counters; out holds its level.
- Operand changes during RUN have no effect.

Optional Feature:
- STEPPER_RAMP_EN defined:
  - The first min(RAMP_STEPS, magnitude) pulses of each axis use half-period width << (RAMP_STEPS - k) for pulse k (0-based).
  - Example: RAMP_STEPS=2, width=2 gives half-periods 8, 4, then 2, 2, ...
  - Internal width counters are widened to PULSE_WIDTH_BITS+RAMP_STEPS bits.
- STEPPER_RAMP_EN undefined: all pulses use width. No ramp logic is present and RAMP_STEPS is unused.

Test Plan:
- Common setup: NUM_AXES=2, 8-bit fields, clk_en every 2nd clk.
- Zero move: pulse_num={0,0}, trigger for 2 clk -> busy for 1 clk, done for 1 clk, out stays 0.
- Signed dual move: axis0=-4/w2, axis1=2/w3 -> dir=2'b01; axis0 gives 4 pulses each 2 ticks high/2 low; axis1 gives 2 pulses 3/3; done once, after axis0's last low phase ends (16 ticks after start).
- Min negative: axis0=-128/w1 -> dir[0]=1; exactly 128 pulses counted; done asserted once.
- Abort mid-move: axis0=10/w2, abort at tick 7 -> out=0 next clk, busy=0, no done; a following trigger starts a fresh move.
- Trigger in RUN plus retrigger: a second trigger pulse while busy is ignored (pulse count unchanged); trigger held through DONE -> a new move starts in the next IDLE cycle.
- With STEPPER_RAMP_EN: axis0=3/w2, RAMP_STEPS=2 -> half-periods 8, 4, 2 ticks.
